pipelined_addsub: RTL

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

---
 rtl/pipelined_addsub.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract split into CHUNK-bit ripple stages, one item per cycle, global stall on out_ready.
// Define ADDSUB_SAT_EN to saturate the sum on signed overflow (cout/ov still report the raw result).
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ov,
  output logic             zero
);
  localparam int CHK    = (CHUNK < 1) ? 1 : CHUNK;
  localparam int STAGES = WIDTH / CHK;
  localparam int LAST   = (STAGES < 1) ? 0 : STAGES - 1;
  localparam int CW     = CHK + 1;

  if ((CHUNK < 1) || ((WIDTH % CHK) != 0) || (STAGES < 1)) begin : g_cfg_err
    $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] c_out;
  logic              cy_q  [STAGES];
  logic [WIDTH-1:0]  xs_q  [STAGES];
  logic [WIDTH-1:0]  ys_q  [STAGES];
  logic [WIDTH-1:0]  ps_q  [STAGES];
  logic [WIDTH-1:0]  x_in  [STAGES];
  logic [WIDTH-1:0]  y_in  [STAGES];
  logic [WIDTH-1:0]  p_in  [STAGES];
  logic [WIDTH-1:0]  p_out [STAGES];
  logic [CHK-1:0]    part  [STAGES];
  logic              advance;
  logic              msb_cin;
  logic              raw_ov;
  logic [WIDTH-1:0]  sum_d;

  assign out_valid = vld_q[LAST];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;

  // Unconsumed operand bits shift down one chunk per stage; finished result chunks shift in from the top.
  always_comb begin
    v_in[0] = in_valid;
    x_in[0] = x;
    y_in[0] = y ^ {WIDTH{sub}};
    p_in[0] = '0;
    c_in[0] = sub;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = vld_q[k-1];
      x_in[k] = xs_q[k-1];
      y_in[k] = ys_q[k-1];
      p_in[k] = ps_q[k-1];
      c_in[k] = cy_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      {c_out[k], part[k]} = CW'(x_in[k][CHK-1:0]) + CW'(y_in[k][CHK-1:0]) + CW'(c_in[k]);
      p_out[k] = (p_in[k] >> CHK) | (WIDTH'(part[k]) << (WIDTH - CHK));
    end
  end

  // Carry into the MSB recovered from the MSB's own sum bit.
  assign msb_cin = part[LAST][CHK-1] ^ x_in[LAST][CHK-1] ^ y_in[LAST][CHK-1];
  assign raw_ov  = c_out[LAST] ^ msb_cin;

`ifdef ADDSUB_SAT_EN
  assign sum_d = raw_ov ? {~p_out[LAST][WIDTH-1], {(WIDTH-1){p_out[LAST][WIDTH-1]}}}
                        : p_out[LAST];
`else
  assign sum_d = p_out[LAST];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ov    <= 1'b0;
      zero  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        xs_q[k] <= '0;
        ys_q[k] <= '0;
        ps_q[k] <= '0;
        cy_q[k] <= 1'b0;
      end
    end else if (advance) begin
      vld_q <= v_in;
      for (int k = 0; k < STAGES; k++) begin
        if (v_in[k]) begin
          xs_q[k] <= x_in[k] >> CHK;
          ys_q[k] <= y_in[k] >> CHK;
          ps_q[k] <= p_out[k];
          cy_q[k] <= c_out[k];
        end
      end
      if (v_in[LAST]) begin
        sum  <= sum_d;
        cout <= c_out[LAST];
        ov   <= raw_ov;
        zero <= (sum_d == '0);
      end
    end
  end
endmodule
